// File: rtl/sb_bus_arbiter.sv
// sb_bus_arbiter: two-master system-bus arbiter.
// It drives the grants, the owner code and the lock flag. It also handles locked
// tenures, bounded bursts, RETRY hand-over, and SPLIT masking with slave release.
// Optional feature macro: ARB_ROUND_ROBIN_EN.
//   Defined   -> ties in IDLE go to the master that did not own the bus last.
//   Undefined -> ties go to M1 (fixed priority).
// The burst limit forces a hand-over in both modes.
module sb_bus_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  input  logic       sb_lock_m1,
  input  logic       sb_lock_m2,
  input  logic       hready,
  input  logic [1:0] resp,
  input  logic [1:0] sb_split_ar,
  output logic       gnt1,
  output logic       gnt2,
  output logic [1:0] sb_masters,
  output logic       sb_mastlock
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_M1 = 2'd1, OWN_M2 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] BMAX    = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [1:0]       RSP_RETRY = 2'b10;
  localparam logic [1:0]       RSP_SPLIT = 2'b11;

  state_t           r_state, w_next;
  logic [1:0]       r_split_mask, w_split_mask;
  logic [CNT_W-1:0] r_beat, w_beat;
`ifdef ARB_ROUND_ROBIN_EN
  logic             r_last, w_last;   // 0 = M1 owned last, 1 = M2 owned last
`endif

  logic [1:0] w_elig;
  logic       w_retry, w_split;
  logic       w_own_req, w_own_lock, w_oth_elig;
  logic       w_hold, w_kick;
  logic       w_mastlock;

  assign w_elig  = {req2, req1} & ~r_split_mask;
  assign w_retry = hready & (resp == RSP_RETRY);
  assign w_split = hready & (resp == RSP_SPLIT);

  // Select the current owner's view. In IDLE these values are don't-care.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    w_oth_elig = 1'b0;
    case (r_state)
      OWN_M1: begin
        w_own_req  = req1;
        w_own_lock = sb_lock_m1;
        w_oth_elig = w_elig[1];
      end
      OWN_M2: begin
        w_own_req  = req2;
        w_own_lock = sb_lock_m2;
        w_oth_elig = w_elig[0];
      end
      default: ;
    endcase
  end

  // The owner keeps the bus while it requests and is locked, under budget, or unopposed.
  // An unlocked RETRY or SPLIT kicks it off. Under lock, both act as a plain RETRY.
  assign w_hold = w_own_req & (w_own_lock | (r_beat < BMAX) | ~w_oth_elig);
  assign w_kick = ~w_own_lock & (w_retry | w_split);

  // Next-state, beat counter, split mask and round-robin pointer.
  always_comb begin
    w_next       = r_state;
    w_beat       = r_beat;
    // Apply the release first, so that a same-cycle SPLIT below wins.
    w_split_mask = r_split_mask & ~sb_split_ar;
`ifdef ARB_ROUND_ROBIN_EN
    w_last       = r_last;
`endif
    case (r_state)
      IDLE: begin
        w_beat = '0;
        case (w_elig)
          2'b01: w_next = OWN_M1;
          2'b10: w_next = OWN_M2;
`ifdef ARB_ROUND_ROBIN_EN
          2'b11: w_next = r_last ? OWN_M1 : OWN_M2;
`else
          2'b11: w_next = OWN_M1;
`endif
          default: w_next = IDLE;
        endcase
      end
      OWN_M1, OWN_M2: begin
        if (!w_hold || w_kick) begin
          // Hand over directly to the other master if it is eligible. Otherwise go idle.
          w_beat = '0;
          if (r_state == OWN_M1) begin
            w_next = w_oth_elig ? OWN_M2 : IDLE;
            if (w_split && !w_own_lock) w_split_mask[0] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            w_last = 1'b0;
`endif
          end else begin
            w_next = w_oth_elig ? OWN_M1 : IDLE;
            if (w_split && !w_own_lock) w_split_mask[1] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            w_last = 1'b1;
`endif
          end
        end else if (hready && (r_beat != CNT_SAT)) begin
          w_beat = r_beat + 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        w_beat = '0;
      end
    endcase
  end

  // The lock flag follows the lock request of the owner for the coming cycle.
  always_comb begin
    w_mastlock = 1'b0;
    case (w_next)
      OWN_M1:  w_mastlock = sb_lock_m1;
      OWN_M2:  w_mastlock = sb_lock_m2;
      default: w_mastlock = 1'b0;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_split_mask <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      r_last       <= 1'b1;
`endif
    end else begin
      r_state      <= w_next;
      r_beat       <= w_beat;
      r_split_mask <= w_split_mask;
`ifdef ARB_ROUND_ROBIN_EN
      r_last       <= w_last;
`endif
    end
  end

  // Registered outputs. They are decoded from the next state, so a grant appears one edge after the request is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt1        <= 1'b0;
      gnt2        <= 1'b0;
      sb_masters  <= 2'b00;
      sb_mastlock <= 1'b0;
    end else begin
      gnt1        <= (w_next == OWN_M1);
      gnt2        <= (w_next == OWN_M2);
      sb_masters  <= {(w_next == OWN_M2), (w_next == OWN_M1)};
      sb_mastlock <= w_mastlock;
    end
  end

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Scoreboard bench for sb_bus_arbiter. The stimulus process steps a bus-level
// ownership model and queues the expected outputs. A monitor compares them after every edge.
module tb_sb_bus_arbiter;
  localparam int BURST = 4;
  localparam int CMAX  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 0, req2 = 0, sb_lock_m1 = 0, sb_lock_m2 = 0, hready = 0;
  logic [1:0] resp = 0, sb_split_ar = 0;
  logic       gnt1, gnt2, sb_mastlock;
  logic [1:0] sb_masters;

  sb_bus_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2),
    .sb_lock_m1(sb_lock_m1), .sb_lock_m2(sb_lock_m2), .hready(hready),
    .resp(resp), .sb_split_ar(sb_split_ar),
    .gnt1(gnt1), .gnt2(gnt2), .sb_masters(sb_masters), .sb_mastlock(sb_mastlock)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0] expq[$];   // {gnt1, gnt2, masters[1:0], mastlock}

  // Reference model: the owner (0 = none, 1 = M1, 2 = M2), the beats used, the masked masters and the last owner.
  int owner = 0, beats = 0, last_own = 2;
  bit masked[1:3];

  task automatic model_reset();
    owner = 0; beats = 0; last_own = 2;
    masked[1] = 0; masked[2] = 0;
  endtask

  task automatic cyc(input bit r1, r2, l1, l2, hr, input bit [1:0] rs, sar);
    bit req[1:3], lck[1:3], el[1:3], nm[1:3];
    bit locked, stay;
    int oth;
    @(negedge clk);
    req1 = r1; req2 = r2; sb_lock_m1 = l1; sb_lock_m2 = l2;
    hready = hr; resp = rs; sb_split_ar = sar;
    req[1] = r1; req[2] = r2; lck[1] = l1; lck[2] = l2;
    el[1] = r1 && !masked[1];
    el[2] = r2 && !masked[2];
    nm[1] = masked[1] && !sar[0];
    nm[2] = masked[2] && !sar[1];
    if (owner == 0) begin
      beats = 0;
      if (el[1] && el[2]) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner = (last_own == 1) ? 2 : 1;
`else
        owner = 1;
`endif
      end else if (el[1]) owner = 1;
      else if (el[2]) owner = 2;
    end else begin
      oth    = 3 - owner;
      locked = lck[owner];
      stay   = req[owner] && (locked || beats < BURST || !el[oth]);
      if (!locked && hr && (rs == 2'b10 || rs == 2'b11)) stay = 0;
      if (stay) begin
        if (hr && beats < CMAX) beats++;
      end else begin
        if (!locked && hr && rs == 2'b11) nm[owner] = 1;
        last_own = owner;
        beats = 0;
        owner = el[oth] ? oth : 0;
      end
    end
    masked[1] = nm[1]; masked[2] = nm[2];
    expq.push_back({owner == 1, owner == 2, owner == 2, owner == 1,
                    (owner == 1) ? l1 : (owner == 2) ? l2 : 1'b0});
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({gnt1, gnt2, sb_masters, sb_mastlock} !== 5'b0) begin
      errors++;
      $display("FAIL %s: got %b required 00000", nm, {gnt1, gnt2, sb_masters, sb_mastlock});
    end
  endtask

  // Monitor: outputs are valid after every edge. Pop one expectation and compare it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expq.size() > 0) begin
        logic [4:0] e;
        e = expq.pop_front();
        checks++;
        if ({gnt1, gnt2, sb_masters, sb_mastlock} !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got g1g2/masters/lock=%b required %b",
                   $time, {gnt1, gnt2, sb_masters, sb_mastlock}, e);
        end
      end
    end
  end

  task automatic rand_cyc();
    int p;
    bit [1:0] rs, sar;
    p  = $urandom_range(0, 9);
    rs = (p < 5) ? 2'b00 : (p == 5) ? 2'b01 : (p < 8) ? 2'b10 : 2'b11;
    sar[0] = ($urandom_range(0, 9) == 0);
    sar[1] = ($urandom_range(0, 9) == 0);
    cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
        $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
        $urandom_range(0, 3) != 0, rs, sar);
  endtask

  initial begin
    model_reset();
    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk) rst = 0;

    // A single requester is granted one edge after sampling.
    repeat (3) cyc(1, 0, 0, 0, 1, 2'b00, 2'b00);
    // Both requesters are held: the grants alternate on the burst limit.
    repeat (24) cyc(1, 1, 0, 0, 1, 2'b00, 2'b00);
    // M1 locked tenure with M2 waiting, then M1 drops its request.
    repeat (12) cyc(1, 1, 1, 0, 1, 2'b00, 2'b00);
    repeat (2) cyc(0, 1, 0, 0, 1, 2'b00, 2'b00);
    // M2 owner gets a SPLIT, then M2 is masked, then released.
    cyc(1, 1, 0, 0, 1, 2'b11, 2'b00);
    repeat (3) cyc(1, 1, 0, 0, 1, 2'b00, 2'b00);
    cyc(1, 1, 0, 0, 1, 2'b00, 2'b10);
    repeat (8) cyc(1, 1, 0, 0, 1, 2'b00, 2'b00);
    // Locked owner receives a SPLIT: the grant is kept and no mask is set.
    repeat (4) cyc(1, 1, 1, 1, 1, 2'b11, 2'b00);
    repeat (3) cyc(1, 1, 0, 0, 0, 2'b00, 2'b00);
    // A SPLIT and a release for the same master arrive together: the set wins.
    cyc(1, 1, 0, 0, 1, 2'b11, 2'b11);
    repeat (6) cyc(1, 1, 0, 0, 1, 2'b00, 2'b00);
    repeat (2) cyc(0, 0, 0, 0, 1, 2'b00, 2'b11);

    // Asynchronous reset in the middle of an M1 tenure.
    repeat (4) cyc(1, 0, 0, 0, 1, 2'b00, 2'b00);
    @(posedge clk);
    #3 rst = 1;
    #1 check_zero("async_reset");
    model_reset();
    expq.delete();
    @(negedge clk);
    @(negedge clk) rst = 0;
    repeat (3) cyc(0, 1, 0, 0, 1, 2'b00, 2'b00);

    // Randomized traffic.
    repeat (2000) rand_cyc();
    // Let the monitor drain the remaining expectations.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
